// File: rtl/alu_bist.sv
// Built-in self-test controller for the 32-bit ALU: drives 16 directed vectors then
// NUM_RANDOM LFSR vectors, checks result/flags against a golden model, reports pass/fail.
module alu_bist #(
  parameter int          SETTLE     = 1,
  parameter int          NUM_RANDOM = 64,
  parameter logic [31:0] SEED       = 32'h1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  ctrl_ALUopcode,
  output logic [4:0]  ctrl_shiftamt,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  input  logic [31:0] data_result,
  input  logic        isNotEqual,
  input  logic        isLessThan,
  input  logic        overflow,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  error_count,
  output logic [15:0] first_fail
);

  localparam logic [4:0]  OP_ADD = 5'b00000;
  localparam logic [4:0]  OP_SUB = 5'b00001;
  localparam logic [4:0]  OP_AND = 5'b00010;
  localparam logic [4:0]  OP_OR  = 5'b00011;
  localparam logic [4:0]  OP_SLL = 5'b00100;
  localparam logic [4:0]  OP_SRA = 5'b00101;
  localparam logic [15:0] LAST_IDX = 16'(16 + NUM_RANDOM - 1);
  localparam logic [3:0]  WAIT_LOAD = 4'(SETTLE - 1);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  sh;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  state_t      state_reg;
  logic [15:0] idx_reg;
  logic [3:0]  wait_cnt_reg;
  logic [31:0] lfsr_reg;

  logic [31:0] lfsr_next;
  vec_t        dir_vec;
  vec_t        rnd_vec;
  vec_t        apply_vec;

  // Next-vector generation: the LFSR steps once before each random vector is applied.
  always_comb begin
    lfsr_next = {lfsr_reg[30:0], lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0]};

    rnd_vec.a  = lfsr_next;
    rnd_vec.sh = lfsr_next[12:8];
    case (lfsr_next[2:0])
      3'd6:    rnd_vec.op = OP_ADD;
      3'd7:    rnd_vec.op = OP_SUB;
      default: rnd_vec.op = {2'b00, lfsr_next[2:0]};
    endcase
    if (rnd_vec.op == OP_SLL || rnd_vec.op == OP_SRA)
      rnd_vec.b = 32'h0;
    else
      rnd_vec.b = {lfsr_next[15:0], lfsr_next[31:16]};

    dir_vec = '{op: OP_OR, sh: 5'd0, a: 32'h0, b: 32'h0};
    case (idx_reg[3:0])
      4'd0:  dir_vec = '{op: OP_OR,  sh: 5'd0,  a: 32'h0000_0000, b: 32'h0000_0000};
      4'd1:  dir_vec = '{op: OP_OR,  sh: 5'd0,  a: 32'hFFFF_FFFF, b: 32'h0000_0000};
      4'd2:  dir_vec = '{op: OP_AND, sh: 5'd0,  a: 32'hFFFF_FFFF, b: 32'h0000_0000};
      4'd3:  dir_vec = '{op: OP_AND, sh: 5'd0,  a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF};
      4'd4:  dir_vec = '{op: OP_ADD, sh: 5'd0,  a: 32'h0000_0001, b: 32'h0000_0001};
      4'd5:  dir_vec = '{op: OP_ADD, sh: 5'd0,  a: 32'h4000_0000, b: 32'h4000_0000};
      4'd6:  dir_vec = '{op: OP_ADD, sh: 5'd0,  a: 32'h8000_0000, b: 32'h8000_0000};
      4'd7:  dir_vec = '{op: OP_SUB, sh: 5'd0,  a: 32'h0000_0000, b: 32'h0000_0000};
      4'd8:  dir_vec = '{op: OP_SUB, sh: 5'd0,  a: 32'h0FFF_FFFF, b: 32'hFFFF_FFFF};
      4'd9:  dir_vec = '{op: OP_SUB, sh: 5'd0,  a: 32'h8000_0001, b: 32'h7FFF_FFFF};
      4'd10: dir_vec = '{op: OP_SUB, sh: 5'd0,  a: 32'h8000_0000, b: 32'h0F00_0000};
      4'd11: dir_vec = '{op: OP_SLL, sh: 5'd1,  a: 32'h0000_0001, b: 32'h0000_0000};
      4'd12: dir_vec = '{op: OP_SLL, sh: 5'd31, a: 32'h0000_0001, b: 32'h0000_0000};
      4'd13: dir_vec = '{op: OP_SRA, sh: 5'd4,  a: 32'h8000_0000, b: 32'h0000_0000};
      4'd14: dir_vec = '{op: OP_SRA, sh: 5'd31, a: 32'h7FFF_FFFF, b: 32'h0000_0000};
      4'd15: dir_vec = '{op: OP_SRA, sh: 5'd0,  a: 32'hFFFF_FFFF, b: 32'h0000_0000};
      default: ;
    endcase

    apply_vec = (idx_reg < 16'd16) ? dir_vec : rnd_vec;
  end

  logic [31:0] exp_sum;
  logic [31:0] exp_diff;
  logic [31:0] exp_result;
  logic        exp_ovf;
  logic        exp_ne;
  logic        exp_lt;
  logic        mismatch;

  // Golden model evaluated on the currently driven vector.
  always_comb begin
    exp_sum    = data_operandA + data_operandB;
    exp_diff   = data_operandA - data_operandB;
    exp_ne     = (data_operandA != data_operandB);
    exp_lt     = ($signed(data_operandA) < $signed(data_operandB));
    exp_ovf    = 1'b0;
    exp_result = 32'h0;
    case (ctrl_ALUopcode)
      OP_ADD: begin
        exp_result = exp_sum;
        exp_ovf    = (data_operandA[31] == data_operandB[31]) && (exp_sum[31] != data_operandA[31]);
      end
      OP_SUB: begin
        exp_result = exp_diff;
        exp_ovf    = (data_operandA[31] != data_operandB[31]) && (exp_diff[31] != data_operandA[31]);
      end
      OP_AND:  exp_result = data_operandA & data_operandB;
      OP_OR:   exp_result = data_operandA | data_operandB;
      OP_SLL:  exp_result = data_operandA << ctrl_shiftamt;
      OP_SRA:  exp_result = $signed(data_operandA) >>> ctrl_shiftamt;
      default: exp_result = 32'h0;
    endcase

    mismatch = (data_result != exp_result);
    if ((ctrl_ALUopcode == OP_ADD || ctrl_ALUopcode == OP_SUB) && (overflow != exp_ovf))
      mismatch = 1'b1;
    if ((ctrl_ALUopcode == OP_SUB) && ((isNotEqual != exp_ne) || (isLessThan != exp_lt)))
      mismatch = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      idx_reg        <= 16'd0;
      wait_cnt_reg   <= 4'd0;
      lfsr_reg       <= SEED;
      ctrl_ALUopcode <= 5'd0;
      ctrl_shiftamt  <= 5'd0;
      data_operandA  <= 32'h0;
      data_operandB  <= 32'h0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      error_count    <= 8'd0;
      first_fail     <= 16'hFFFF;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (state_reg == S_DONE && busy) begin
            // One cycle after the final check, the result becomes visible.
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (error_count == 8'd0);
          end else if (start) begin
            state_reg   <= S_APPLY;
            idx_reg     <= 16'd0;
            lfsr_reg    <= SEED;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            error_count <= 8'd0;
            first_fail  <= 16'hFFFF;
          end
        end
        S_APPLY: begin
          if (idx_reg >= 16'd16)
            lfsr_reg <= lfsr_next;
          ctrl_ALUopcode <= apply_vec.op;
          ctrl_shiftamt  <= apply_vec.sh;
          data_operandA  <= apply_vec.a;
          data_operandB  <= apply_vec.b;
          wait_cnt_reg   <= WAIT_LOAD;
          state_reg      <= (SETTLE == 0) ? S_CHECK : S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_reg == 4'd0)
            state_reg <= S_CHECK;
          else
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
        end
        S_CHECK: begin
          if (mismatch) begin
            if (error_count != 8'hFF)
              error_count <= error_count + 8'd1;
            if (first_fail == 16'hFFFF)
              first_fail <= idx_reg;
          end
          if (idx_reg == LAST_IDX) begin
            state_reg <= S_DONE;
          end else begin
            idx_reg   <= idx_reg + 16'd1;
            state_reg <= S_APPLY;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: a reference ALU with selectable faults drives two
// controller instances (directed-only and long random run).
module tb_alu_bist;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_d = 1'b0;
  logic start_r = 1'b0;
  int   fault = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] result;
    logic        ne;
    logic        lt;
    logic        ovf;
  } alu_out_t;

  // Reference ALU; fault 1: overflow tied 0, 2: lt = raw diff sign, 3: result bit 0 inverted.
  function automatic alu_out_t alu_model(input logic [4:0] op, input logic [4:0] sh,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input int flt);
    alu_out_t o;
    logic [31:0] s, d;
    s = a + b;
    d = a - b;
    o.ne  = (a != b);
    o.lt  = ($signed(a) < $signed(b));
    o.ovf = 1'b0;
    case (op)
      5'd0: begin o.result = s; o.ovf = (a[31] == b[31]) && (s[31] != a[31]); end
      5'd1: begin o.result = d; o.ovf = (a[31] != b[31]) && (d[31] != a[31]); end
      5'd2: o.result = a & b;
      5'd3: o.result = a | b;
      5'd4: o.result = a << sh;
      5'd5: o.result = $signed(a) >>> sh;
      default: o.result = 32'h0;
    endcase
    if (flt == 1) o.ovf = 1'b0;
    if (flt == 2) o.lt = d[31];
    if (flt == 3) o.result[0] = ~o.result[0];
    return o;
  endfunction

  logic [4:0]  op_d, sh_d, op_r, sh_r;
  logic [31:0] a_d, b_d, a_r, b_r;
  alu_out_t    alu_d, alu_r;
  logic        busy_d, done_d, pass_d, busy_r, done_r, pass_r;
  logic [7:0]  ec_d, ec_r;
  logic [15:0] ff_d, ff_r;

  always_comb alu_d = alu_model(op_d, sh_d, a_d, b_d, fault);
  always_comb alu_r = alu_model(op_r, sh_r, a_r, b_r, fault);

  alu_bist #(.SETTLE(1), .NUM_RANDOM(0), .SEED(32'h1)) u_dir (
    .clock(clock), .reset(reset), .start(start_d),
    .ctrl_ALUopcode(op_d), .ctrl_shiftamt(sh_d),
    .data_operandA(a_d), .data_operandB(b_d),
    .data_result(alu_d.result), .isNotEqual(alu_d.ne),
    .isLessThan(alu_d.lt), .overflow(alu_d.ovf),
    .busy(busy_d), .done(done_d), .pass(pass_d),
    .error_count(ec_d), .first_fail(ff_d)
  );

  alu_bist #(.SETTLE(0), .NUM_RANDOM(300), .SEED(32'h1)) u_rnd (
    .clock(clock), .reset(reset), .start(start_r),
    .ctrl_ALUopcode(op_r), .ctrl_shiftamt(sh_r),
    .data_operandA(a_r), .data_operandB(b_r),
    .data_result(alu_r.result), .isNotEqual(alu_r.ne),
    .isLessThan(alu_r.lt), .overflow(alu_r.ovf),
    .busy(busy_r), .done(done_r), .pass(pass_r),
    .error_count(ec_r), .first_fail(ff_r)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start so it is sampled at the next edge E; returns at E+1ns.
  task automatic pulse_d();
    start_d = 1'b1; tick(1); start_d = 1'b0;
  endtask

  task automatic pulse_r();
    start_r = 1'b1; tick(1); start_r = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("rst_busy", 32'(busy_d), 0);
    chk("rst_done", 32'(done_d), 0);
    chk("rst_pass", 32'(pass_d), 0);
    chk("rst_ec", 32'(ec_d), 0);
    chk("rst_ff", 32'(ff_d), 32'h0000FFFF);
    chk("rst_opA", a_d, 0);
    reset = 1'b0;
    tick(2);
    $display("reset released, idle outputs checked");

    // Correct ALU, directed only: done 49 cycles after start.
    fault = 0;
    pulse_d();
    chk("run1_busy_E", 32'(busy_d), 1);
    tick(16);
    chk("run1_v5_op", 32'(op_d), 0);
    chk("run1_v5_a", a_d, 32'h40000000);
    chk("run1_v5_b", b_d, 32'h40000000);
    tick(32);
    chk("run1_done_E48", 32'(done_d), 0);
    chk("run1_busy_E48", 32'(busy_d), 1);
    tick(1);
    chk("run1_done_E49", 32'(done_d), 1);
    chk("run1_busy_E49", 32'(busy_d), 0);
    chk("run1_pass", 32'(pass_d), 1);
    chk("run1_ec", 32'(ec_d), 0);
    chk("run1_ff", 32'(ff_d), 32'h0000FFFF);
    $display("run1 correct ALU: ec=%0d ff=%h pass=%0d", ec_d, ff_d, pass_d);

    // Overflow tied 0: vectors 5,6,9,10 fail.
    fault = 1;
    pulse_d();
    chk("run2_done_clr", 32'(done_d), 0);
    tick(18);
    chk("run2_ec_mid", 32'(ec_d), 1);
    chk("run2_ff_mid", 32'(ff_d), 5);
    tick(31);
    chk("run2_done", 32'(done_d), 1);
    chk("run2_ec", 32'(ec_d), 4);
    chk("run2_ff", 32'(ff_d), 5);
    chk("run2_pass", 32'(pass_d), 0);
    $display("run2 ovf tied 0: ec=%0d ff=%0d pass=%0d", ec_d, ff_d, pass_d);

    // isLessThan from raw diff sign: vectors 9 and 10 fail.
    fault = 2;
    pulse_d();
    tick(49);
    chk("run3_done", 32'(done_d), 1);
    chk("run3_ec", 32'(ec_d), 2);
    chk("run3_ff", 32'(ff_d), 9);
    chk("run3_pass", 32'(pass_d), 0);
    $display("run3 raw lt: ec=%0d ff=%0d pass=%0d", ec_d, ff_d, pass_d);

    // start mid-run must be ignored.
    fault = 1;
    pulse_d();
    tick(19);
    start_d = 1'b1; tick(1); start_d = 1'b0;
    tick(28);
    chk("run4_done_E48", 32'(done_d), 0);
    tick(1);
    chk("run4_done_E49", 32'(done_d), 1);
    chk("run4_ec", 32'(ec_d), 4);
    $display("run4 mid-run start: ec=%0d done=%0d", ec_d, done_d);

    // Asynchronous reset mid-run.
    pulse_d();
    tick(20);
    chk("run5_ec_pre", 32'(ec_d), 1);
    reset = 1'b1;
    #1;
    chk("run5_busy", 32'(busy_d), 0);
    chk("run5_ec", 32'(ec_d), 0);
    chk("run5_ff", 32'(ff_d), 32'h0000FFFF);
    chk("run5_op", 32'(op_d), 0);
    chk("run5_a", a_d, 0);
    chk("run5_b", b_d, 0);
    reset = 1'b0;
    tick(3);
    chk("run5_idle_busy", 32'(busy_d), 0);
    chk("run5_idle_done", 32'(done_d), 0);
    $display("run5 reset mid-run: busy=%0d ec=%0d", busy_d, ec_d);

    // Random run twice with correct ALU: identical LFSR vectors, done at E+633.
    fault = 0;
    for (int r = 0; r < 2; r++) begin
      pulse_r();
      tick(33);
      chk("rnd_v16_op", 32'(op_r), 3);
      chk("rnd_v16_a", a_r, 32'h00000003);
      chk("rnd_v16_b", b_r, 32'h00030000);
      tick(2);
      chk("rnd_v17_op", 32'(op_r), 0);
      chk("rnd_v17_a", a_r, 32'h00000006);
      chk("rnd_v17_b", b_r, 32'h00060000);
      tick(597);
      chk("rnd_done_E632", 32'(done_r), 0);
      tick(1);
      chk("rnd_done_E633", 32'(done_r), 1);
      chk("rnd_pass", 32'(pass_r), 1);
      chk("rnd_ec", 32'(ec_r), 0);
      $display("random run %0d: ec=%0d pass=%0d", r, ec_r, pass_r);
    end

    // Every vector fails: error_count saturates at 255.
    fault = 3;
    pulse_r();
    tick(508);
    chk("sat_ec_254", 32'(ec_r), 254);
    tick(2);
    chk("sat_ec_255", 32'(ec_r), 255);
    tick(123);
    chk("sat_done", 32'(done_r), 1);
    chk("sat_ec_end", 32'(ec_r), 255);
    chk("sat_ff", 32'(ff_r), 0);
    chk("sat_pass", 32'(pass_r), 0);
    $display("saturation run: ec=%0d ff=%0d pass=%0d", ec_r, ff_r, pass_r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
